// File: rtl/stream_delay_pkg.sv
// stream_delay_pkg: LFSR constants and step function shared by the stream delay blocks
package stream_delay_pkg;
  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hCAFE;
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction
endpackage

// File: rtl/stream_delay_lfsr.sv
// stream_delay_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing only when en_i is high
module stream_delay_lfsr
  import stream_delay_pkg::*;
#(
  parameter logic [15:0] Seed = DefaultSeed
)(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);
  always_ff @(posedge clk_i)
    if (!rst_ni || clr_i) lfsr_o <= Seed;
    else if (en_i) lfsr_o <= lfsr_step(lfsr_o);
endmodule

// File: rtl/stream_delay_buffered.sv
// stream_delay_buffered: in-order valid/ready latency emulator with up to Depth overlapping per-beat delays
// Optional STREAM_DELAY_FALLTHROUGH_EN: zero-delay beats bypass an empty buffer combinationally.
module stream_delay_buffered
  import stream_delay_pkg::*;
#(
  parameter type         payload_t  = logic,
  parameter int unsigned Depth      = 4,
  parameter int unsigned DelayWidth = 8,
  parameter logic [15:0] Seed       = DefaultSeed
)(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic [DelayWidth-1:0]        delay_i,
  input  logic                         random_en_i,
  input  payload_t                     payload_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output payload_t                     payload_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o
);
  localparam int unsigned UW = $clog2(Depth + 1);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  typedef struct packed {
    payload_t              payload;
    logic [DelayWidth-1:0] cnt;
  } slot_t;
  slot_t mem [Depth];
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [15:0] lfsr;
  logic [DelayWidth-1:0] d, cnt_new;
  logic empty, head_ready, ft, accept, store, pop;
  stream_delay_lfsr #(.Seed(Seed)) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr_i),
    .en_i  (accept),
    .lfsr_o(lfsr)
  );
  assign empty = usage_o == '0;
  assign ready_o = usage_o != UW'(Depth);
  assign d = random_en_i ? DelayWidth'(lfsr) & delay_i : delay_i;
  assign cnt_new = d == '0 ? '0 : d - 1'b1;
  assign head_ready = !empty && mem[rd_ptr].cnt == '0;
`ifdef STREAM_DELAY_FALLTHROUGH_EN
  assign ft = empty && d == '0;
`else
  assign ft = 1'b0;
`endif
  assign valid_o = ft ? valid_i : head_ready;
  assign payload_o = ft ? payload_i : mem[rd_ptr].payload;
  assign accept = valid_i && ready_o;
  assign store = accept && !(ft && ready_i);
  assign pop = head_ready && ready_i;
  always_ff @(posedge clk_i)
    if (!rst_ni || clr_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      usage_o <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr == LastPtr ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + 1'b1;
      usage_o <= usage_o + UW'(store) - UW'(pop);
    end
  // Free slots count down too; harmless, since a store overwrites the counter.
  always_ff @(posedge clk_i)
    for (int i = 0; i < Depth; i++)
      if (store && wr_ptr == PtrW'(i)) mem[i] <= {payload_i, cnt_new};
      else if (mem[i].cnt != '0) mem[i].cnt <= mem[i].cnt - 1'b1;
endmodule

// File: tb/tb_stream_delay_buffered.sv
// tb_stream_delay_buffered: randomized scoreboard bench; each beat's release cycle comes from a release-time model
module tb_stream_delay_buffered;
  localparam int Depth = 4;
  localparam int DW = 8;
  localparam logic [15:0] Seed = 16'hCAFE;
  typedef logic [15:0] pl_t;
  typedef struct {
    pl_t    data;
    longint rel;
  } exp_t;
  logic clk = 0, rst_ni = 0, clr_i = 0, random_en_i = 0, valid_i = 0, ready_i = 0;
  logic [DW-1:0] delay_i = '0;
  pl_t payload_i = '0, payload_o;
  logic ready_o, valid_o;
  logic [2:0] usage_o;
  int checks = 0, errors = 0;
  bit armed = 0;
  exp_t q[$];
  logic [15:0] m_lfsr = Seed;
  pl_t n = '0;
  always #5 clk = ~clk;
  stream_delay_buffered #(.payload_t(pl_t), .Depth(Depth), .DelayWidth(DW), .Seed(Seed)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .delay_i    (delay_i),
    .random_en_i(random_en_i),
    .payload_i  (payload_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .payload_o  (payload_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .usage_o    (usage_o)
  );
  function automatic int cur_delay();
    return int'(random_en_i ? (m_lfsr[DW-1:0] & delay_i) : delay_i);
  endfunction
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask
  // Accepted beats enter the scoreboard with their earliest release cycle.
  always @(posedge clk) begin
    longint k;
    int d;
    k = longint'(($time - 15) / 10);
    if (!rst_ni || clr_i) begin
      q.delete();
      m_lfsr = Seed;
    end else if (valid_i && ready_o) begin
      d = cur_delay();
`ifdef STREAM_DELAY_FALLTHROUGH_EN
      if (!(q.size() == 0 && d == 0 && ready_i)) q.push_back('{payload_i, k + (d == 0 ? 1 : d)});
`else
      q.push_back('{payload_i, k + (d == 0 ? 1 : d)});
`endif
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end
  // Head is presented exactly when it is oldest and its release cycle has come.
  always @(negedge clk) if (armed) begin
    longint k;
    bit ev, ft;
    pl_t ep;
    k = longint'(($time - 10) / 10);
    ft = 0;
`ifdef STREAM_DELAY_FALLTHROUGH_EN
    ft = q.size() == 0 && cur_delay() == 0;
`endif
    ev = ft ? valid_i : (q.size() > 0 && k >= q[0].rel);
    ep = ft ? payload_i : (q.size() > 0 ? q[0].data : '0);
    check("usage_o", longint'(usage_o), longint'(q.size()));
    check("ready_o", longint'(ready_o), longint'(q.size() < Depth));
    check("valid_o", longint'(valid_o), longint'(ev));
    if (ev && valid_o) check("payload_o", longint'(payload_o), longint'(ep));
    if (ev && ready_i && !ft) void'(q.pop_front());
  end
  task automatic step(bit v, logic [DW-1:0] d, bit r, bit ren);
    valid_i = v;
    payload_i = n;
    delay_i = d;
    ready_i = r;
    random_en_i = ren;
    n++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1;
    armed = 1;
    for (int i = 0; i < 8; i++) step(1, 8'd3, 1, 0);
    repeat (6) step(0, 8'd3, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 8'd1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'd1, 1, 0);
    repeat (3) step(0, 8'd1, 1, 0);
    for (int i = 0; i < 24; i++) step(1'($urandom_range(0, 1)), 8'h07, 1, 1);
    repeat (8) step(0, 8'h07, 1, 1);
    step(1, 8'd5, 1, 0);
    step(1, 8'd1, 1, 0);
    repeat (8) step(0, 8'd1, 1, 0);
    repeat (3) step(1, 8'd9, 1, 0);
    clr_i = 1;
    step(0, 8'd9, 1, 0);
    clr_i = 0;
    for (int i = 0; i < 8; i++) step(1, 8'h07, 1, 1);
    repeat (8) step(0, 8'h07, 1, 1);
    repeat (3) step(1, 8'd9, 1, 0);
    rst_ni = 0;
    step(0, 8'd9, 1, 0);
    rst_ni = 1;
    for (int i = 0; i < 8; i++) step(1, 8'h07, 1, 1);
    for (int i = 0; i < 400; i++) begin
      clr_i = $urandom_range(0, 59) == 0;
      step(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end
    clr_i = 0;
    repeat (40) step(0, 8'd0, 1, 0);
    check("drain", longint'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
